// File: rtl/tcp_pkg.sv
// -----------------------------------------------------------------------------
// tcp_pkg
// Shared definitions for the TCP receive path (tcp_rx_assembler, tcp_client):
// word width, packet size, checksum field position and assembler state codes.
// No ports (package).
// -----------------------------------------------------------------------------
package tcp_pkg;

  localparam int TCP_WORD_W    = 32;
  localparam int TCP_PKT_WORDS = 7;
  localparam int TCP_PKT_W     = TCP_WORD_W * TCP_PKT_WORDS;

  // Checksum field occupies the upper halfword of word 4.
  localparam int TCP_CSUM_LO   = 144;
  localparam int TCP_CSUM_HI   = 159;
  localparam int TCP_CSUM_WORD = TCP_CSUM_LO / TCP_WORD_W;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HOLD    = 2'd2
  } rx_state_t;

  // Extract the checksum field from an assembled packet.
  function automatic logic [15:0] csum_field(input logic [TCP_PKT_W-1:0] pkt);
    return pkt[TCP_CSUM_HI:TCP_CSUM_LO];
  endfunction

endpackage

// File: rtl/tcp_csum16.sv
// -----------------------------------------------------------------------------
// tcp_csum16
// 16-bit ones'-complement adder with end-around carry.
// Ports:
//   a, b : 16-bit addends
//   y    : 16-bit ones'-complement sum
// -----------------------------------------------------------------------------
module tcp_csum16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  logic [16:0] raw;

  // The folded carry can never overflow again: max is 0xFFFE + 1.
  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    y   = raw[15:0] + {15'd0, raw[16]};
  end

endmodule

// File: rtl/tcp_rx_assembler.sv
// -----------------------------------------------------------------------------
// tcp_rx_assembler
// Collects PKT_WORDS 32-bit receive words into one TCP packet, verifies the
// ones'-complement checksum on the fly and presents good packets downstream
// with a valid/ready handshake. Short, long and bad-checksum frames are dropped
// and counted.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   word_in       : receive word; word k lands in packet bits [32k+31:32k]
//   word_valid    : word_in valid
//   word_last     : word_in is the last word of its frame
//   word_ready    : word accepted this cycle when word_valid is also high
//   packet_out    : assembled packet (tcp_pkg layout)
//   packet_valid  : packet_out holds a checked packet
//   packet_ready  : downstream consumes packet_out
//   csum_err      : one-cycle pulse, packet dropped for bad checksum
//   frame_err     : one-cycle pulse, frame dropped for wrong length
//   drop_cnt      : saturating count of dropped frames
// -----------------------------------------------------------------------------
module tcp_rx_assembler
  import tcp_pkg::*;
#(
  parameter int PKT_WORDS = TCP_PKT_WORDS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [TCP_WORD_W-1:0]           word_in,
  input  logic                            word_valid,
  input  logic                            word_last,
  output logic                            word_ready,
  output logic [TCP_WORD_W*PKT_WORDS-1:0] packet_out,
  output logic                            packet_valid,
  input  logic                            packet_ready,
  output logic                            csum_err,
  output logic                            frame_err,
  output logic [7:0]                      drop_cnt
);

  localparam int               CNT_W    = $clog2(PKT_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_WORDS - 1);
  localparam logic [CNT_W-1:0] CSUM_IDX = CNT_W'(TCP_CSUM_WORD);

  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [15:0]      sum, sum_nxt;
  logic             valid_nxt;
  logic             csum_err_nxt;
  logic             frame_err_nxt;
  logic             wr_en;
  logic             accept;

  logic [15:0]      hi_add;
  logic [15:0]      sum_hi;
  logic [15:0]      sum_word;

  assign word_ready = !rst && (state != ST_HOLD);
  assign accept     = word_valid && word_ready;

  // The checksum field itself is excluded from the running sum.
  assign hi_add = (cnt == CSUM_IDX) ? 16'h0000 : word_in[31:16];

  tcp_csum16 u_csum_hi (
    .a (sum),
    .b (hi_add),
    .y (sum_hi)
  );

  tcp_csum16 u_csum_lo (
    .a (sum_hi),
    .b (word_in[15:0]),
    .y (sum_word)
  );

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    sum_nxt       = sum;
    valid_nxt     = packet_valid;
    csum_err_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    wr_en         = 1'b0;

    case (state)
      ST_COLLECT: begin
        if (accept) begin
          wr_en = 1'b1;
          if (cnt == LAST_IDX) begin
            cnt_nxt = '0;
            sum_nxt = '0;
            if (word_last) begin
              // Field was stored with word 4; compare with the final sum.
              if (~sum_word == packet_out[TCP_CSUM_HI:TCP_CSUM_LO]) begin
                state_nxt = ST_HOLD;
                valid_nxt = 1'b1;
              end else begin
                csum_err_nxt = 1'b1;
              end
            end else begin
              frame_err_nxt = 1'b1;
              state_nxt     = ST_DRAIN;
            end
          end else if (word_last) begin
            frame_err_nxt = 1'b1;
            cnt_nxt       = '0;
            sum_nxt       = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
            sum_nxt = sum_word;
          end
        end
      end

      ST_DRAIN: begin
        if (accept && word_last) begin
          state_nxt = ST_COLLECT;
        end
      end

      ST_HOLD: begin
        if (packet_ready) begin
          valid_nxt = 1'b0;
          state_nxt = ST_COLLECT;
          cnt_nxt   = '0;
          sum_nxt   = '0;
        end
      end

      default: begin
        state_nxt = ST_COLLECT;
        cnt_nxt   = '0;
        sum_nxt   = '0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // ---- control registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_COLLECT;
      cnt          <= '0;
      sum          <= '0;
      packet_valid <= 1'b0;
      csum_err     <= 1'b0;
      frame_err    <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      sum          <= sum_nxt;
      packet_valid <= valid_nxt;
      csum_err     <= csum_err_nxt;
      frame_err    <= frame_err_nxt;
      if ((csum_err_nxt || frame_err_nxt) && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // ---- packet slot storage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      packet_out <= '0;
    end else begin
      for (int k = 0; k < PKT_WORDS; k++) begin
        if (wr_en && (cnt == CNT_W'(k))) begin
          packet_out[TCP_WORD_W*k +: TCP_WORD_W] <= word_in;
        end
      end
    end
  end

endmodule
